// File: rtl/compressed_encoder_pkg.sv
// compressed_encoder_pkg
// Shared types and constants for the streaming RVC encoder: base and
// compressed opcodes, funct3 values, the parcel type that the rule table
// produces, the packer state encoding and a small immediate-range helper.
package compressed_encoder_pkg;

  // Base RV64 opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Compressed quadrant opcodes
  localparam logic [1:0] OPC_C1 = 2'b01;
  localparam logic [1:0] OPC_C2 = 2'b10;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_D    = 3'b011;

  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [15:0] C_NOP        = 16'h0001;
  localparam logic [15:0] C_EBREAK     = 16'h9002;

  // One output parcel: a compressed halfword lives in instr[15:0]
  typedef struct packed {
    logic [31:0] instr;
    logic        is_16;
  } rvc_parcel_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } pack_state_e;

  // True when a 12-bit signed immediate fits in 6 signed bits
  function automatic logic fits_simm6(input logic [11:0] imm);
    return (imm[11:5] == 7'h00) || (imm[11:5] == 7'h7F);
  endfunction

endpackage

// File: rtl/compressed_encoder_if.sv
// compressed_encoder_if
// Bundles the instruction input stream, flush request and packed-word
// output stream of the encoder.
//   slave  : encoder side (consumes instructions, produces words)
//   master : environment side (produces instructions, consumes words)
// Signals: instr_i/instr_valid_i/instr_ready_o input handshake,
// flush_i pad request, word_o/word_valid_o/word_ready_i output handshake,
// idle_o status, cnt_compressed_o compression counter.
interface compressed_encoder_if;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic        flush_i;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        idle_o;
  logic [31:0] cnt_compressed_o;

  modport slave (
    input  instr_i, instr_valid_i, flush_i, word_ready_i,
    output instr_ready_o, word_o, word_valid_o, idle_o, cnt_compressed_o
  );

  modport master (
    output instr_i, instr_valid_i, flush_i, word_ready_i,
    input  instr_ready_o, word_o, word_valid_o, idle_o, cnt_compressed_o
  );
endinterface

// File: rtl/compressed_encoder_rvc_compress.sv
// rvc_compress
// Purely combinational rule table: rewrites a 32-bit RV64 instruction into
// its exact 16-bit RVC equivalent when one exists, otherwise passes it
// through. Already-compressed inputs (bits [1:0] != 11) pass as 16-bit.
// PC-relative instructions are deliberately absent from the table since
// packing moves instruction addresses.
// Ports: instr_i (32-bit instruction in), parcel_o (parcel + length flag).
module rvc_compress
  import compressed_encoder_pkg::*;
(
  input  logic [31:0] instr_i,
  output rvc_parcel_t parcel_o
);

  logic [6:0]  opcode_s;
  logic [4:0]  rd_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [11:0] imm_i_s;
  logic [11:0] imm_st_s;
  logic [15:0] c_s;
  logic        hit_s;

  assign opcode_s = instr_i[6:0];
  assign rd_s     = instr_i[11:7];
  assign funct3_s = instr_i[14:12];
  assign rs1_s    = instr_i[19:15];
  assign rs2_s    = instr_i[24:20];
  assign funct7_s = instr_i[31:25];
  assign imm_i_s  = instr_i[31:20];
  assign imm_st_s = {instr_i[31:25], instr_i[11:7]};

  // Rule table: find the compressed form, if any
  always_comb begin
    c_s   = 16'h0000;
    hit_s = 1'b0;
    if (instr_i[1:0] != 2'b11) begin
      c_s   = instr_i[15:0];
      hit_s = 1'b1;
    end else begin
      case (opcode_s)
        OPC_OP_IMM: begin
          if (instr_i == INSTR_NOP) begin
            c_s   = C_NOP;
            hit_s = 1'b1;
          end else if ((funct3_s == F3_ADDI) && (rd_s != 5'd0) && (rs1_s == 5'd0)
                       && fits_simm6(imm_i_s)) begin
            c_s   = {3'b010, imm_i_s[5], rd_s, imm_i_s[4:0], OPC_C1};
            hit_s = 1'b1;
          end else if ((funct3_s == F3_ADDI) && (rd_s != 5'd0) && (rs1_s == rd_s)
                       && (imm_i_s != 12'd0) && fits_simm6(imm_i_s)) begin
            c_s   = {3'b000, imm_i_s[5], rd_s, imm_i_s[4:0], OPC_C1};
            hit_s = 1'b1;
          end else if ((funct3_s == F3_SLLI) && (instr_i[31:26] == 6'd0) && (rd_s != 5'd0)
                       && (rs1_s == rd_s) && (instr_i[25:20] != 6'd0)) begin
            c_s   = {3'b000, instr_i[25], rd_s, instr_i[24:20], OPC_C2};
            hit_s = 1'b1;
          end else begin
            hit_s = 1'b0;
          end
        end
        OPC_OP: begin
          if ((funct7_s == 7'd0) && (funct3_s == 3'd0) && (rd_s != 5'd0) && (rs2_s != 5'd0)) begin
            if (rs1_s == 5'd0) begin
              c_s   = {4'b1000, rd_s, rs2_s, OPC_C2};
              hit_s = 1'b1;
            end else if (rs1_s == rd_s) begin
              c_s   = {4'b1001, rd_s, rs2_s, OPC_C2};
              hit_s = 1'b1;
            end else begin
              hit_s = 1'b0;
            end
          end else begin
            hit_s = 1'b0;
          end
        end
        OPC_LOAD: begin
          // Offset bits above the encodable range must be zero (non-negative)
          if ((funct3_s == F3_W) && (rs1_s == 5'd2) && (rd_s != 5'd0)
              && (imm_i_s[11:8] == 4'd0) && (imm_i_s[1:0] == 2'd0)) begin
            c_s   = {3'b010, imm_i_s[5], rd_s, imm_i_s[4:2], imm_i_s[7:6], OPC_C2};
            hit_s = 1'b1;
          end else if ((funct3_s == F3_D) && (rs1_s == 5'd2) && (rd_s != 5'd0)
                       && (imm_i_s[11:9] == 3'd0) && (imm_i_s[2:0] == 3'd0)) begin
            c_s   = {3'b011, imm_i_s[5], rd_s, imm_i_s[4:3], imm_i_s[8:6], OPC_C2};
            hit_s = 1'b1;
          end else begin
            hit_s = 1'b0;
          end
        end
        OPC_STORE: begin
          if ((funct3_s == F3_W) && (rs1_s == 5'd2)
              && (imm_st_s[11:8] == 4'd0) && (imm_st_s[1:0] == 2'd0)) begin
            c_s   = {3'b110, imm_st_s[5:2], imm_st_s[7:6], rs2_s, OPC_C2};
            hit_s = 1'b1;
          end else if ((funct3_s == F3_D) && (rs1_s == 5'd2)
                       && (imm_st_s[11:9] == 3'd0) && (imm_st_s[2:0] == 3'd0)) begin
            c_s   = {3'b111, imm_st_s[5:3], imm_st_s[8:6], rs2_s, OPC_C2};
            hit_s = 1'b1;
          end else begin
            hit_s = 1'b0;
          end
        end
        OPC_JALR: begin
          if ((funct3_s == 3'd0) && (imm_i_s == 12'd0) && (rs1_s != 5'd0)) begin
            if (rd_s == 5'd0) begin
              c_s   = {4'b1000, rs1_s, 5'd0, OPC_C2};
              hit_s = 1'b1;
            end else if (rd_s == 5'd1) begin
              c_s   = {4'b1001, rs1_s, 5'd0, OPC_C2};
              hit_s = 1'b1;
            end else begin
              hit_s = 1'b0;
            end
          end else begin
            hit_s = 1'b0;
          end
        end
        OPC_SYSTEM: begin
          if (instr_i == INSTR_EBREAK) begin
            c_s   = C_EBREAK;
            hit_s = 1'b1;
          end else begin
            hit_s = 1'b0;
          end
        end
        default: begin
          hit_s = 1'b0;
        end
      endcase
    end
  end

  // Form the parcel: compressed halfword or the untouched instruction
  always_comb begin
    if (hit_s) begin
      parcel_o.instr = {16'h0000, c_s};
      parcel_o.is_16 = 1'b1;
    end else begin
      parcel_o.instr = instr_i;
      parcel_o.is_16 = 1'b0;
    end
  end

endmodule

// File: rtl/compressed_encoder.sv
// compressed_encoder
// Streaming RVC encoder and halfword packer. Each accepted instruction is
// compressed where possible, and the resulting 16/32-bit parcels are packed
// little-endian into 32-bit words (earlier parcel in [15:0]).
// Ports: clk_i clock, rst_i synchronous active-high reset,
// bus (slave modport): instruction input handshake, flush request,
// packed-word output handshake, idle status and compression counter.
module compressed_encoder
  import compressed_encoder_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  compressed_encoder_if.slave  bus
);

  rvc_parcel_t parcel_s;
  pack_state_e state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [31:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ready_s;
  logic        accept_s;
  logic        flush_fire_s;
  logic        is_32_in_s;

  rvc_compress u_compress (
    .instr_i  (bus.instr_i),
    .parcel_o (parcel_s)
  );

  // Single output register: a new beat is taken whenever the word slot frees
  assign ready_s      = !word_valid_q || bus.word_ready_i;
  assign accept_s     = bus.instr_valid_i && ready_s;
  // An input beat always wins over a flush request
  assign flush_fire_s = bus.flush_i && !bus.instr_valid_i && ready_s && (state_q == ST_HALF);
  assign is_32_in_s   = (bus.instr_i[1:0] == 2'b11);

  assign bus.instr_ready_o    = ready_s;
  assign bus.word_o           = word_q;
  assign bus.word_valid_o     = word_valid_q;
  assign bus.idle_o           = (state_q == ST_EMPTY) && !word_valid_q;
  assign bus.cnt_compressed_o = cnt_q;

  // Packer next state, output word and counter
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    word_d       = word_q;
    word_valid_d = word_valid_q && !bus.word_ready_i;
    cnt_d        = cnt_q;
    if (accept_s) begin
      if (is_32_in_s && parcel_s.is_16) begin
        cnt_d = cnt_q + 32'd1;
      end else begin
        cnt_d = cnt_q;
      end
      case (state_q)
        ST_EMPTY: begin
          if (parcel_s.is_16) begin
            hold_d  = parcel_s.instr[15:0];
            state_d = ST_HALF;
          end else begin
            word_d       = parcel_s.instr;
            word_valid_d = 1'b1;
            state_d      = ST_EMPTY;
          end
        end
        ST_HALF: begin
          word_d       = {parcel_s.instr[15:0], hold_q};
          word_valid_d = 1'b1;
          if (parcel_s.is_16) begin
            state_d = ST_EMPTY;
          end else begin
            // Upper half of a 32-bit instruction straddles into the next word
            hold_d  = parcel_s.instr[31:16];
            state_d = ST_HALF;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end else if (flush_fire_s) begin
      word_d       = {C_NOP, hold_q};
      word_valid_d = 1'b1;
      state_d      = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // State, hold, output and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_EMPTY;
      hold_q       <= 16'h0000;
      word_q       <= 32'h0000_0000;
      word_valid_q <= 1'b0;
      cnt_q        <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_compressed_encoder.sv
// Self-checking bench for compressed_encoder: a queue-based packing model
// fed by hand-encoded parcels, a per-cycle output monitor, and literal
// expectations for the key sequences.
module tb_compressed_encoder;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  compressed_encoder_if bus ();

  compressed_encoder dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] half_q[$];
  logic [31:0] exp_words_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] exp_cnt = 32'd0;
  logic        stalled = 1'b0;
  logic [31:0] stall_word = 32'd0;
  logic        done_b = 1'b0;
  logic [15:0] ready_pat = 16'hB2E5;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] exp;
    logic        is16;
  } vec_t;
  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Model: the stream is just a sequence of halfwords, paired in order
  function automatic void model_pair();
    logic [15:0] a, b;
    while (half_q.size() >= 2) begin
      a = half_q.pop_front();
      b = half_q.pop_front();
      exp_words_q.push_back({b, a});
    end
  endfunction

  function automatic void model_beat(input logic [31:0] p, input bit is16, input bit was32);
    half_q.push_back(p[15:0]);
    if (!is16) half_q.push_back(p[31:16]);
    if (was32 && is16) exp_cnt = exp_cnt + 32'd1;
    model_pair();
  endfunction

  task automatic send(input logic [31:0] ins, input logic [31:0] expp, input bit is16);
    int n = 0;
    @(negedge clk_i);
    bus.instr_i       = ins;
    bus.instr_valid_i = 1'b1;
    #1;
    while (!bus.instr_ready_o && n < 50) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    chk("send_ready", 32'(bus.instr_ready_o), 32'd1);
    model_beat(expp, is16, ins[1:0] == 2'b11);
    @(posedge clk_i);
    #1;
    bus.instr_valid_i = 1'b0;
  endtask

  task automatic do_flush();
    int n = 0;
    @(negedge clk_i);
    bus.word_ready_i = 1'b1;
    bus.flush_i      = 1'b1;
    if (half_q.size() == 1) begin
      half_q.push_back(16'h0001);
      model_pair();
    end
    #1;
    while (!bus.idle_o && n < 50) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    chk("flush_idle", 32'(bus.idle_o), 32'd1);
    bus.flush_i = 1'b0;
  endtask

  task automatic wait_words(input int target);
    int n = 0;
    while (obs_q.size() < target && n < 100) begin
      @(negedge clk_i);
      #3;
      n++;
    end
    chk("word_count", 32'(obs_q.size()), 32'(target));
  endtask

  // Output monitor: every transfer against the model, stability under stall
  always @(negedge clk_i) begin
    #2;
    if (rst_i) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 32'(bus.word_valid_o), 32'd1);
        chk("stall_word", bus.word_o, stall_word);
      end
      if (bus.word_valid_o && bus.word_ready_i) begin
        stalled = 1'b0;
        obs_q.push_back(bus.word_o);
        if (exp_words_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_word: got %h expected none", bus.word_o);
        end else begin
          chk("word", bus.word_o, exp_words_q.pop_front());
        end
      end else if (bus.word_valid_o) begin
        stalled    = 1'b1;
        stall_word = bus.word_o;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0, t1;
    vecs[0]  = {32'h00150513, 32'h00000505, 1'b1};  // addi x10,x10,1
    vecs[1]  = {32'h00000013, 32'h00000001, 1'b1};  // nop
    vecs[2]  = {32'hFFF00293, 32'h000052FD, 1'b1};  // li x5,-1
    vecs[3]  = {32'h00351513, 32'h0000050E, 1'b1};  // slli x10,x10,3
    vecs[4]  = {32'h00900433, 32'h00008426, 1'b1};  // mv x8,x9
    vecs[5]  = {32'h00940433, 32'h00009426, 1'b1};  // add x8,x8,x9
    vecs[6]  = {32'h00812283, 32'h000042A2, 1'b1};  // lw x5,8(x2)
    vecs[7]  = {32'h01013303, 32'h00006342, 1'b1};  // ld x6,16(x2)
    vecs[8]  = {32'h00912623, 32'h0000C626, 1'b1};  // sw x9,12(x2)
    vecs[9]  = {32'h00813C23, 32'h0000EC22, 1'b1};  // sd x8,24(x2)
    vecs[10] = {32'h00008067, 32'h00008082, 1'b1};  // jr x1
    vecs[11] = {32'h000280E7, 32'h00009282, 1'b1};  // jalr x5
    vecs[12] = {32'h00100073, 32'h00009002, 1'b1};  // ebreak
    vecs[13] = {32'h008000EF, 32'h008000EF, 1'b0};  // jal x1,8
    vecs[14] = {32'h00052283, 32'h00052283, 1'b0};  // lw x5,0(x10)
    vecs[15] = {32'h02050513, 32'h02050513, 1'b0};  // addi imm 32
    vecs[16] = {32'h00612283, 32'h00612283, 1'b0};  // lw misaligned
    vecs[17] = {32'h00050513, 32'h00050513, 1'b0};  // addi imm 0
    vecs[18] = {32'hFE000293, 32'h00005281, 1'b1};  // li x5,-32
    vecs[19] = {32'hDEAD4505, 32'h00004505, 1'b1};  // pre-compressed
    vecs[20] = {32'h20013303, 32'h20013303, 1'b0};  // ld off 512
    vecs[21] = {32'h1E813C23, 32'h0000FFA2, 1'b1};  // sd x8,504(x2)

    bus.instr_i       = 32'd0;
    bus.instr_valid_i = 1'b0;
    bus.flush_i       = 1'b0;
    bus.word_ready_i  = 1'b1;
    rst_i             = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_word", bus.word_o, 32'd0);
    chk("rst_valid", 32'(bus.word_valid_o), 32'd0);
    chk("rst_idle", 32'(bus.idle_o), 32'd1);
    chk("rst_cnt", bus.cnt_compressed_o, 32'd0);
    chk("rst_ready", 32'(bus.instr_ready_o), 32'd1);
    rst_i = 1'b0;

    // Two c.addi parcels fill one word
    send(32'h00150513, 32'h00000505, 1'b1);
    send(32'h00150513, 32'h00000505, 1'b1);
    wait_words(1);
    @(negedge clk_i);
    #1;
    chk("pair_word", obs_q[0], 32'h05050505);
    chk("pair_cnt", bus.cnt_compressed_o, 32'd2);
    chk("pair_idle", 32'(bus.idle_o), 32'd1);

    // Uncompressible lw from EMPTY
    send(32'h00052283, 32'h00052283, 1'b0);
    wait_words(2);
    chk("lw_word", obs_q[1], 32'h00052283);
    chk("lw_cnt", bus.cnt_compressed_o, 32'd2);

    // HALF + 32-bit, then flush pads with c.nop
    send(32'h00150513, 32'h00000505, 1'b1);
    send(32'h00052283, 32'h00052283, 1'b0);
    wait_words(3);
    chk("straddle_word", obs_q[2], 32'h22830505);
    chk("straddle_idle", 32'(bus.idle_o), 32'd0);
    do_flush();
    chk("flush_word", obs_q[3], 32'h00010005);

    // jal is never compressed
    send(32'h008000EF, 32'h008000EF, 1'b0);
    wait_words(5);
    chk("jal_word", obs_q[4], 32'h008000EF);
    chk("jal_cnt", bus.cnt_compressed_o, 32'd3);

    // Back-pressure: ebreak pair held stable, third ebreak waits
    @(negedge clk_i);
    bus.word_ready_i = 1'b0;
    send(32'h00100073, 32'h00009002, 1'b1);
    send(32'h00100073, 32'h00009002, 1'b1);
    @(negedge clk_i);
    #1;
    chk("stall_hold_valid", 32'(bus.word_valid_o), 32'd1);
    chk("stall_hold_word", bus.word_o, 32'h90029002);
    chk("stall_not_ready", 32'(bus.instr_ready_o), 32'd0);
    fork
      send(32'h00100073, 32'h00009002, 1'b1);
      begin
        repeat (3) @(negedge clk_i);
        bus.word_ready_i = 1'b1;
      end
    join
    chk("release_word", obs_q[5], 32'h90029002);
    do_flush();
    chk("ebreak_flush_word", obs_q[6], 32'h00019002);
    chk("ebreak_cnt", bus.cnt_compressed_o, 32'd6);

    // Full table at full throughput
    send(vecs[0].instr, vecs[0].exp, vecs[0].is16);
    t0 = $time;
    for (int i = 1; i < 22; i++) send(vecs[i].instr, vecs[i].exp, vecs[i].is16);
    t1 = $time;
    chk("throughput_cycles", 32'((t1 - t0) / 10), 32'd21);
    do_flush();

    // Full table under a back-pressure pattern
    done_b = 1'b0;
    fork
      begin
        for (int i = 0; i < 22; i++) send(vecs[i].instr, vecs[i].exp, vecs[i].is16);
        done_b = 1'b1;
      end
      begin
        int k = 0;
        while (!done_b) begin
          @(negedge clk_i);
          bus.word_ready_i = ready_pat[k % 16];
          k++;
        end
      end
    join
    do_flush();
    chk("table_cnt_model", bus.cnt_compressed_o, exp_cnt);
    chk("table_cnt", bus.cnt_compressed_o, 32'd36);

    // Reset in HALF with a beat offered: everything discarded
    send(32'h00150513, 32'h00000505, 1'b1);
    @(negedge clk_i);
    bus.instr_i       = 32'h00150513;
    bus.instr_valid_i = 1'b1;
    rst_i             = 1'b1;
    half_q.delete();
    exp_words_q.delete();
    exp_cnt = 32'd0;
    @(negedge clk_i);
    #1;
    chk("mid_rst_valid", 32'(bus.word_valid_o), 32'd0);
    chk("mid_rst_word", bus.word_o, 32'd0);
    chk("mid_rst_idle", 32'(bus.idle_o), 32'd1);
    chk("mid_rst_cnt", bus.cnt_compressed_o, 32'd0);
    rst_i             = 1'b0;
    bus.instr_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("post_rst_valid", 32'(bus.word_valid_o), 32'd0);
    send(32'h00052283, 32'h00052283, 1'b0);
    wait_words(obs_q.size() + 1);
    chk("post_rst_word", obs_q[obs_q.size() - 1], 32'h00052283);

    repeat (3) @(negedge clk_i);
    chk("model_drained", 32'(exp_words_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
